// File: rtl/pm_jtag_tap_ctrl.sv
// pm_jtag_tap_ctrl: IEEE 1149.1 TAP controller for the PM-control JTAG port.
// It runs the 16-state TAP FSM and holds the instruction register. It decodes
// the instruction into BYPASS, IDCODE or one of DR_NUM user data registers.
// It generates the capture/shift/update strobes for the selected register and
// registers the serial output onto tdo on the falling edge of reg_tck.
// Optional feature: define PM_TAP_IDCODE_EN to build the 32-bit IDCODE
// register. With that macro the reset instruction becomes IDCODE_OP.
module pm_jtag_tap_ctrl #(
  parameter int                  IR_WIDTH     = 4,
  parameter int                  DR_NUM       = 2,
  parameter logic [IR_WIDTH-1:0] USER_OP_BASE = 4'h2,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 4'h1,
  parameter logic [31:0]         IDCODE_VAL   = 32'h0000_0001
) (
  input  logic              reg_tck,
  input  logic              reg_rst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output logic [3:0]        tap_state,
  input  logic              bypass_out,
  output logic              bypass_cap_en,
  output logic              bypass_shift_en,
  output logic [DR_NUM-1:0] dr_sel,
  output logic              dr_capture_en,
  output logic              dr_shift_en,
  output logic              dr_update_en,
  input  logic [DR_NUM-1:0] dr_tdo
);

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_t;

`ifdef PM_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_IR = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR = {IR_WIDTH{1'b1}};
`endif

  // The capture pattern ends in 2'b01, as 1149.1 requires.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_t          state;
  tap_state_t          state_next;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_active;
  logic [DR_NUM-1:0]   user_sel;
  logic                any_user;
  logic                sel_bypass;
  logic                dr_serial;
`ifdef PM_TAP_IDCODE_EN
  logic                sel_idcode;
  logic [31:0]         idcode_shift;
`endif

  // TAP state register; reset forces Test-Logic-Reset at once.
  always_ff @(posedge reg_tck or posedge reg_rst) begin
    if (reg_rst) state <= TLR;
    else         state <= state_next;
  end

  // Standard 1149.1 transition graph, steered by tms.
  always_comb begin
    state_next = state;
    case (state)
      TLR:     state_next = tms ? TLR    : RTI;
      RTI:     state_next = tms ? SEL_DR : RTI;
      SEL_DR:  state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_next = tms ? EX1_DR : SH_DR;
      SH_DR:   state_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_next = tms ? UPD_DR : PAU_DR;
      PAU_DR:  state_next = tms ? EX2_DR : PAU_DR;
      EX2_DR:  state_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_next = tms ? SEL_DR : RTI;
      SEL_IR:  state_next = tms ? TLR    : CAP_IR;
      CAP_IR:  state_next = tms ? EX1_IR : SH_IR;
      SH_IR:   state_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_next = tms ? UPD_IR : PAU_IR;
      PAU_IR:  state_next = tms ? EX2_IR : PAU_IR;
      EX2_IR:  state_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // IR shift register: capture the fixed pattern, then shift right with tdi
  // entering at the MSB.
  always_ff @(posedge reg_tck or posedge reg_rst) begin
    if (reg_rst) begin
      ir_shift <= '0;
    end else if (state == CAP_IR) begin
      ir_shift <= IR_CAPTURE;
    end else if (state == SH_IR) begin
      ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
    end
  end

  // Active IR: reloads the reset instruction on any entry into TLR. It takes
  // the shifted value on the edge that leaves Update-IR, so a DR scan never
  // disturbs it.
  always_ff @(posedge reg_tck or posedge reg_rst) begin
    if (reg_rst) begin
      ir_active <= RESET_IR;
    end else if (state_next == TLR) begin
      ir_active <= RESET_IR;
    end else if (state == UPD_IR) begin
      ir_active <= ir_shift;
    end
  end

  // Instruction decode. All-ones always means BYPASS and takes priority.
  // Opcodes that match nothing also fall back to BYPASS.
  always_comb begin
    user_sel = '0;
    for (int i = 0; i < DR_NUM; i++) begin
      if (!(&ir_active) && (ir_active == USER_OP_BASE + IR_WIDTH'(i))) begin
        user_sel[i] = 1'b1;
      end
    end
  end

  assign any_user = |user_sel;

`ifdef PM_TAP_IDCODE_EN
  assign sel_idcode = !(&ir_active) && !any_user && (ir_active == IDCODE_OP);
  assign sel_bypass = !any_user && !sel_idcode;

  // IDCODE register: loads the fixed ID on capture and shifts out LSB first.
  always_ff @(posedge reg_tck or posedge reg_rst) begin
    if (reg_rst) begin
      idcode_shift <= IDCODE_VAL;
    end else if (sel_idcode && (state == CAP_DR)) begin
      idcode_shift <= IDCODE_VAL;
    end else if (sel_idcode && (state == SH_DR)) begin
      idcode_shift <= {tdi, idcode_shift[31:1]};
    end
  end
`else
  assign sel_bypass = !any_user;
`endif

  assign tap_state       = state;
  assign dr_sel          = user_sel;
  assign bypass_cap_en   = sel_bypass && (state == CAP_DR);
  assign bypass_shift_en = sel_bypass && (state == SH_DR);
  assign dr_capture_en   = any_user && (state == CAP_DR);
  assign dr_shift_en     = any_user && (state == SH_DR);
  assign dr_update_en    = any_user && (state == UPD_DR);

  // Serial output of whichever data register the current instruction selects.
  always_comb begin
    dr_serial = bypass_out;
    if (any_user) dr_serial = |(dr_tdo & user_sel);
`ifdef PM_TAP_IDCODE_EN
    if (sel_idcode) dr_serial = idcode_shift[0];
`endif
  end

  // tdo is launched on the falling edge and holds its value outside shift
  // states.
  always_ff @(negedge reg_tck or posedge reg_rst) begin
    if (reg_rst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_IR) || (state == SH_DR);
      if (state == SH_IR)      tdo <= ir_shift[0];
      else if (state == SH_DR) tdo <= dr_serial;
    end
  end

endmodule

// File: tb/tb_pm_jtag_tap_ctrl.sv
// tb_pm_jtag_tap_ctrl: testbench for pm_jtag_tap_ctrl. It provides the
// external bypass register and two 8-bit user data registers. It compares the
// TAP against a table-driven state model and against scan results worked out
// from the IEEE 1149.1 scan rules.
module tb_pm_jtag_tap_ctrl;

  localparam int         DR_N      = 2;
  localparam logic [3:0] USER_OP   = 4'h2;
  localparam logic [3:0] IDCODE_OP = 4'h1;
  localparam logic [31:0] IDCODE_V = 32'h1A2B_3C4F;

  localparam logic [7:0] CAPV [DR_N] = '{8'h3C, 8'hC3};

  // IEEE 1149.1 next-state table, indexed by state, for tms=0 and tms=1.
  localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  // tms sequences from Test-Logic-Reset to each state, applied left to right.
  localparam string PATHS [16] = '{"", "0", "01", "010", "0100", "0101", "01010",
                                   "010101", "01011", "011", "0110", "01100",
                                   "01101", "011010", "0110101", "011011"};

  logic            reg_tck;
  logic            reg_rst;
  logic            tms;
  logic            tdi;
  logic            tdo;
  logic            tdo_en;
  logic [3:0]      tap_state;
  logic            bypass_out;
  logic            bypass_cap_en;
  logic            bypass_shift_en;
  logic [DR_N-1:0] dr_sel;
  logic            dr_capture_en;
  logic            dr_shift_en;
  logic            dr_update_en;
  logic [DR_N-1:0] dr_tdo;

  logic       bypass_reg = 1'b0;
  logic [7:0] user_sr  [DR_N] = '{8'h00, 8'h00};
  logic [7:0] user_upd [DR_N] = '{8'h00, 8'h00};
  logic [7:0] exp_upd  [DR_N] = '{8'h00, 8'h00};

  int tests_run    = 0;
  int tests_failed = 0;
  int model_state  = 0;
  int cap_cnt, sh_cnt, upd_cnt, byp_cap_cnt, byp_sh_cnt;

  pm_jtag_tap_ctrl #(
    .IR_WIDTH     (4),
    .DR_NUM       (DR_N),
    .USER_OP_BASE (USER_OP),
    .IDCODE_OP    (IDCODE_OP),
    .IDCODE_VAL   (IDCODE_V)
  ) dut (
    .reg_tck         (reg_tck),
    .reg_rst         (reg_rst),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .tap_state       (tap_state),
    .bypass_out      (bypass_out),
    .bypass_cap_en   (bypass_cap_en),
    .bypass_shift_en (bypass_shift_en),
    .dr_sel          (dr_sel),
    .dr_capture_en   (dr_capture_en),
    .dr_shift_en     (dr_shift_en),
    .dr_update_en    (dr_update_en),
    .dr_tdo          (dr_tdo)
  );

  initial reg_tck = 1'b0;
  always #5 reg_tck = ~reg_tck;

  assign bypass_out = bypass_reg;
  assign dr_tdo     = {user_sr[1][0], user_sr[0][0]};

  // External data registers, driven only by the TAP's strobes.
  always @(posedge reg_tck) begin
    if (bypass_cap_en)        bypass_reg <= 1'b0;
    else if (bypass_shift_en) bypass_reg <= tdi;
    for (int i = 0; i < DR_N; i++) begin
      if (dr_sel[i] && dr_capture_en)    user_sr[i]  <= CAPV[i];
      else if (dr_sel[i] && dr_shift_en) user_sr[i]  <= {tdi, user_sr[i][7:1]};
      if (dr_sel[i] && dr_update_en)     user_upd[i] <= user_sr[i];
    end
  end

  // One tck period. Inputs are driven after a falling edge; outputs are sampled
  // just after the next falling edge, and the strobes are tallied there.
  task automatic tck_step(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge reg_tck);
    model_state = t_ms ? NXT1[model_state] : NXT0[model_state];
    @(negedge reg_tck);
    #1;
    if (dr_capture_en)   cap_cnt++;
    if (dr_shift_en)     sh_cnt++;
    if (dr_update_en)    upd_cnt++;
    if (bypass_cap_en)   byp_cap_cnt++;
    if (bypass_shift_en) byp_sh_cnt++;
  endtask

  task automatic clear_counts();
    cap_cnt = 0; sh_cnt = 0; upd_cnt = 0; byp_cap_cnt = 0; byp_sh_cnt = 0;
  endtask

  task automatic do_reset();
    reg_rst = 1'b1;
    @(negedge reg_tck);
    #1;
    reg_rst = 1'b0;
    model_state = 0;
  endtask

  // IR scan from Run-Test/Idle back to Run-Test/Idle; val goes in LSB first.
  task automatic ir_scan(input logic [3:0] val, output logic [3:0] got);
    got = '0;
    tck_step(1'b1, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      got[j] = tdo;
      tests_run++;
      if (tdo_en !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL ir_scan_tdo_en: bit %0d tdo_en=%b expected 1", j, tdo_en);
      end
      tck_step(j == 3, val[j]);
    end
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  // DR scan of n bits from Run-Test/Idle back to Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [31:0] data, output logic [31:0] got);
    got = '0;
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    for (int j = 0; j < n; j++) begin
      got[j] = tdo;
      tests_run++;
      if (tdo_en !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL dr_scan_tdo_en: bit %0d tdo_en=%b expected 1", j, tdo_en);
      end
      tck_step(j == n - 1, data[j]);
    end
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reg_rst = 1'b1;
    tms = 1'b0;
    tdi = 1'b0;
    repeat (2) @(negedge reg_tck);
    #1;
    tests_run++;
    if (tap_state !== 4'h0 || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: state=%0h tdo=%b tdo_en=%b expected 0/0/0",
               tap_state, tdo, tdo_en);
    end
    tests_run++;
    if ({dr_sel, dr_capture_en, dr_shift_en, dr_update_en, bypass_cap_en, bypass_shift_en} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: dr_sel=%b cap=%b sh=%b upd=%b bcap=%b bsh=%b expected all 0",
               dr_sel, dr_capture_en, dr_shift_en, dr_update_en, bypass_cap_en, bypass_shift_en);
    end
    reg_rst = 1'b0;
    model_state = 0;
  endtask

  task automatic test_fsm_states();
    string p;
    for (int s = 0; s < 16; s++) begin
      repeat (5) tck_step(1'b1, 1'b0);
      p = PATHS[s];
      for (int k = 0; k < p.len(); k++) tck_step(p.getc(k) == 8'h31, 1'b0);
      tests_run++;
      if (tap_state !== 4'(s)) begin
        tests_failed++;
        $display("[TB] FAIL fsm_reach: state=%0h expected %0h", tap_state, s);
      end
      repeat (5) tck_step(1'b1, 1'b0);
      tests_run++;
      if (tap_state !== 4'h0) begin
        tests_failed++;
        $display("[TB] FAIL fsm_five_ones: from %0h state=%0h expected 0", s, tap_state);
      end
      tck_step(1'b0, 1'b0);
      tests_run++;
      if (tap_state !== 4'h1) begin
        tests_failed++;
        $display("[TB] FAIL fsm_to_rti: from %0h state=%0h expected 1", s, tap_state);
      end
    end
    // Random walk against the transition table. With tdi held at 0 no user
    // opcode can reach the active IR.
    for (int k = 0; k < 200; k++) begin
      tck_step(1'($urandom), 1'b0);
      tests_run++;
      if (tap_state !== 4'(model_state)) begin
        tests_failed++;
        $display("[TB] FAIL fsm_walk: step %0d state=%0h expected %0h", k, tap_state, model_state);
      end
    end
    repeat (5) tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  task automatic test_ir_dr_bypass();
    logic [3:0]  irgot;
    logic [31:0] got;
    logic [7:0]  data;
    logic [7:0]  expv;
    for (int k = 0; k < 3; k++) begin
      data = (k == 0) ? 8'hA5 : 8'($urandom);
      ir_scan(4'hF, irgot);
      tests_run++;
      if (irgot !== 4'b0001) begin
        tests_failed++;
        $display("[TB] FAIL ir_capture: got %b expected 0001", irgot);
      end
      clear_counts();
      dr_scan(8, {24'h0, data}, got);
      expv = {data[6:0], 1'b0};
      tests_run++;
      if (got[7:0] !== expv) begin
        tests_failed++;
        $display("[TB] FAIL bypass_scan: data=%0h tdo stream=%0h expected %0h", data, got[7:0], expv);
      end
      tests_run++;
      if (tdo_en !== 1'b0 || tdo !== expv[7]) begin
        tests_failed++;
        $display("[TB] FAIL tdo_hold: tdo_en=%b tdo=%b expected 0/%b", tdo_en, tdo, expv[7]);
      end
      tests_run++;
      if (byp_cap_cnt != 1 || byp_sh_cnt != 8 || upd_cnt != 0) begin
        tests_failed++;
        $display("[TB] FAIL bypass_strobes: cap=%0d sh=%0d upd=%0d expected 1/8/0",
                 byp_cap_cnt, byp_sh_cnt, upd_cnt);
      end
    end
  endtask

  task automatic test_idcode();
    logic [31:0] data;
    logic [31:0] got;
    logic [31:0] expv;
    do_reset();
    tck_step(1'b0, 1'b0);
    data = $urandom;
    dr_scan(32, data, got);
`ifdef PM_TAP_IDCODE_EN
    expv = IDCODE_V;
`else
    expv = {data[30:0], 1'b0};
`endif
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("[TB] FAIL reset_instr_scan: tdo stream=%0h expected %0h", got, expv);
    end
  endtask

  task automatic test_user_dr();
    int          i;
    logic [3:0]  irgot;
    logic [31:0] got;
    logic [7:0]  data;
    for (int k = 0; k < 5; k++) begin
      i = (k == 0) ? 1 : int'($urandom_range(0, DR_N - 1));
      data = 8'($urandom);
      ir_scan(USER_OP + 4'(i), irgot);
      tests_run++;
      if (dr_sel !== 2'(1 << i)) begin
        tests_failed++;
        $display("[TB] FAIL user_dr_sel: dr_sel=%b expected %b", dr_sel, 2'(1 << i));
      end
      clear_counts();
      dr_scan(8, {24'h0, data}, got);
      exp_upd[i] = data;
      tests_run++;
      if (got[7:0] !== CAPV[i]) begin
        tests_failed++;
        $display("[TB] FAIL user_dr_capture: dr %0d tdo stream=%0h expected %0h", i, got[7:0], CAPV[i]);
      end
      tests_run++;
      if (cap_cnt != 1 || sh_cnt != 8 || upd_cnt != 1) begin
        tests_failed++;
        $display("[TB] FAIL user_dr_strobes: cap=%0d sh=%0d upd=%0d expected 1/8/1", cap_cnt, sh_cnt, upd_cnt);
      end
      tests_run++;
      if (byp_cap_cnt != 0 || byp_sh_cnt != 0) begin
        tests_failed++;
        $display("[TB] FAIL user_dr_bypass_quiet: bcap=%0d bsh=%0d expected 0/0", byp_cap_cnt, byp_sh_cnt);
      end
      tests_run++;
      if (user_upd[0] !== exp_upd[0] || user_upd[1] !== exp_upd[1]) begin
        tests_failed++;
        $display("[TB] FAIL user_dr_update: dr0=%0h dr1=%0h expected %0h/%0h",
                 user_upd[0], user_upd[1], exp_upd[0], exp_upd[1]);
      end
    end
  endtask

  task automatic test_unused_opcode();
    logic [3:0]  irgot;
    logic [31:0] got;
    logic [7:0]  data;
    data = 8'($urandom);
    ir_scan(4'h9, irgot);
    tests_run++;
    if (dr_sel !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL unused_op_sel: dr_sel=%b expected 00", dr_sel);
    end
    clear_counts();
    dr_scan(8, {24'h0, data}, got);
    tests_run++;
    if (got[7:0] !== {data[6:0], 1'b0} || upd_cnt != 0 || byp_cap_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL unused_op_bypass: stream=%0h upd=%0d bcap=%0d expected %0h/0/1",
               got[7:0], upd_cnt, byp_cap_cnt, {data[6:0], 1'b0});
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0]  irgot;
    logic [31:0] got;
    logic        expb;
    ir_scan(USER_OP + 4'd1, irgot);
    clear_counts();
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    repeat (3) tck_step(1'b0, 1'($urandom));
    #2;
    reg_rst = 1'b1;
    #1;
    tests_run++;
    if (tap_state !== 4'h0 || tdo_en !== 1'b0 || dr_update_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_scan_reset: state=%0h tdo_en=%b upd=%b expected 0/0/0",
               tap_state, tdo_en, dr_update_en);
    end
    @(negedge reg_tck);
    #1;
    reg_rst = 1'b0;
    model_state = 0;
    tests_run++;
    if (upd_cnt != 0 || user_upd[1] !== exp_upd[1] || dr_sel !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL mid_scan_abort: upd=%0d dr1=%0h dr_sel=%b expected 0/%0h/00",
               upd_cnt, user_upd[1], dr_sel, exp_upd[1]);
    end
    tck_step(1'b0, 1'b0);
    dr_scan(1, 32'h0, got);
`ifdef PM_TAP_IDCODE_EN
    expb = IDCODE_V[0];
`else
    expb = 1'b0;
`endif
    tests_run++;
    if (got[0] !== expb) begin
      tests_failed++;
      $display("[TB] FAIL mid_scan_reset_ir: first bit=%b expected %b", got[0], expb);
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_fsm_states();
    test_ir_dr_bypass();
    test_idcode();
    test_user_dr();
    test_unused_opcode();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
